// File: rtl/tlb_op_ctrl.sv
// TLB maintenance op sequencer: accepts one op from commit, issues one MMU strobe,
// captures search results / CSR read enable, and reports completion on a fixed 4-cycle cadence.
module tlb_op_ctrl #(
    parameter int IDX_W = 5,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid_i,
    input  logic [OP_W-1:0]  op_type_i,
    output logic             op_ready_o,
    input  logic             flush_i,
    input  logic             srch_found_i,
    input  logic [IDX_W-1:0] srch_idx_i,
    output logic             tlbsrch_en_o,
    output logic             tlbrd_en_o,
    output logic             tlbwr_en_o,
    output logic             tlbfill_en_o,
    output logic             invtlb_en_o,
    output logic [IDX_W-1:0] rand_idx_o,
    output logic             rd_we_o,
    output logic             trans_stall_o,
    output logic             rsp_valid_o,
    output logic [OP_W-1:0]  rsp_op_o,
    output logic             rsp_found_o,
    output logic [IDX_W-1:0] rsp_idx_o,
    output logic             rsp_err_o,
    output logic             refetch_o
);

    localparam logic [OP_W-1:0] OP_SRCH = OP_W'(0);
    localparam logic [OP_W-1:0] OP_RD   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_WR   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_FILL = OP_W'(3);
    localparam logic [OP_W-1:0] OP_INV  = OP_W'(4);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             kill_q, kill_d;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] rand_q, rand_d;
    logic             found_q, found_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic accept, busy, is_mod, illegal, kill;

    assign busy    = (state_q != IDLE);
    assign is_mod  = (op_q == OP_WR) || (op_q == OP_FILL) || (op_q == OP_INV);
    assign illegal = (op_q > OP_INV);
    // Flush only cancels ops with no architectural side effect; it bites in the cycle it arrives.
    assign kill    = kill_q || (busy && flush_i && !is_mod);
    assign accept  = (state_q == IDLE) && op_valid_i && !flush_i;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        kill_d  = kill;
        rand_d  = rand_q;
        found_d = found_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (accept) begin
                    state_d = ISSUE;
                    op_d    = op_type_i;
                    if (op_type_i == OP_FILL) rand_d = cnt_q;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d = DONE;
                if (op_q == OP_SRCH && !kill) begin
                    found_d = srch_found_i;
                    idx_d   = srch_idx_i;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
            rand_q  <= '0;
            found_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            kill_q  <= kill_d;
            cnt_q   <= cnt_q + IDX_W'(1);
            rand_q  <= rand_d;
            found_q <= found_d;
            idx_q   <= idx_d;
        end
    end

    assign op_ready_o    = (state_q == IDLE) && !flush_i;
    assign tlbsrch_en_o  = (state_q == ISSUE) && (op_q == OP_SRCH);
    assign tlbrd_en_o    = (state_q == ISSUE) && (op_q == OP_RD);
    assign tlbwr_en_o    = (state_q == ISSUE) && (op_q == OP_WR);
    assign tlbfill_en_o  = (state_q == ISSUE) && (op_q == OP_FILL);
    assign invtlb_en_o   = (state_q == ISSUE) && (op_q == OP_INV);
    assign rd_we_o       = (state_q == WAIT) && (op_q == OP_RD) && !kill;
    assign trans_stall_o = ((state_q == ISSUE) || (state_q == WAIT)) && is_mod;
    assign rsp_valid_o   = (state_q == DONE) && !kill;
    assign rsp_err_o     = rsp_valid_o && illegal;
    assign refetch_o     = (state_q == DONE) && is_mod;
    assign rsp_op_o      = op_q;
    assign rsp_found_o   = found_q;
    assign rsp_idx_o     = idx_q;
    assign rand_idx_o    = rand_q;

endmodule
